// File: rtl/riscv_pkg.sv
// Shared CPU definitions: pipeline stage payloads and elastic-stage defaults.
package riscv_pkg;

  localparam int PIPE_STAGE_DEPTH = 2;
  localparam int PIPE_STAT_W      = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_reg_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
  } id_ex_reg_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
  } ex_mem_reg_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
  } mem_wb_reg_t;

endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Saturating event counter; clr wins over inc, holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// DEPTH-entry in-order elastic stage; 1-cycle latency, in_ready depends only on
// registered occupancy so no combinational path runs from out_ready to in_ready.
module pipe_stage_elastic
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = PIPE_STAGE_DEPTH,
  parameter int CNT_W = PIPE_STAT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  input  logic                       stat_clr,
  output logic [CNT_W-1:0]           stall_cycles
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [OCC_W-1:0] count;
  logic             push;
  logic             pop;

  // Explicit wrap so non-power-of-two depths never index past the array.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign occupancy = count;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid && !out_ready),
    .clr   (stat_clr),
    .value (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Two stages (DEPTH=2/CNT_W=16 and DEPTH=3/CNT_W=4) driven in parallel and
// compared every cycle against queue-based reference models plus directed checks.
module tb_pipe_stage_elastic;

  localparam int DA = 2;
  localparam int DB = 3;
  localparam int MA = 65535;
  localparam int MB = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        stat_clr = 1'b0;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [31:0] a_out_data, b_out_data;
  logic [1:0]  a_occ, b_occ;
  logic [15:0] a_stall;
  logic [3:0]  b_stall;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int sa = 0;
  int sb = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.WIDTH(32), .DEPTH(DA), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .stat_clr(stat_clr), .stall_cycles(a_stall)
  );

  pipe_stage_elastic #(.WIDTH(32), .DEPTH(DB), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .occupancy(b_occ), .stat_clr(stat_clr), .stall_cycles(b_stall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_compare();
    chk("a_in_ready",  32'(a_in_ready),  32'(qa.size() < DA));
    chk("a_out_valid", 32'(a_out_valid), 32'(qa.size() != 0));
    chk("a_out_data",  a_out_data,       (qa.size() != 0) ? qa[0] : 32'h0);
    chk("a_occupancy", 32'(a_occ),       32'(qa.size()));
    chk("a_stall",     32'(a_stall),     32'(sa));
    chk("b_in_ready",  32'(b_in_ready),  32'(qb.size() < DB));
    chk("b_out_valid", 32'(b_out_valid), 32'(qb.size() != 0));
    chk("b_out_data",  b_out_data,       (qb.size() != 0) ? qb[0] : 32'h0);
    chk("b_occupancy", 32'(b_occ),       32'(qb.size()));
    chk("b_stall",     32'(b_stall),     32'(sb));
  endtask

  task automatic model_step();
    bit a_push, a_pop, b_push, b_pop;
    a_push = in_valid && (qa.size() < DA) && !flush;
    a_pop  = (qa.size() != 0) && out_ready && !flush;
    b_push = in_valid && (qb.size() < DB) && !flush;
    b_pop  = (qb.size() != 0) && out_ready && !flush;
    if (stat_clr) sa = 0;
    else if ((qa.size() != 0) && !out_ready && (sa < MA)) sa++;
    if (stat_clr) sb = 0;
    else if ((qb.size() != 0) && !out_ready && (sb < MB)) sb++;
    if (flush) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_pop) void'(qa.pop_front());
      if (a_push) qa.push_back(in_data);
      if (b_pop) void'(qb.pop_front());
      if (b_push) qb.push_back(in_data);
    end
  endtask

  // Inputs are set at posedge+1; outputs are compared at posedge+2, then the clock advances.
  task automatic tick();
    #1;
    model_compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    sa = 0;
    sb = 0;
  endtask

  initial begin
    // Reset and single beat
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(a_in_ready),  32'h1);
    chk("rst_out_valid", 32'(a_out_valid), 32'h0);
    chk("rst_out_data",  a_out_data,       32'h0);
    chk("rst_occupancy", 32'(a_occ),       32'h0);
    chk("rst_stall",     32'(a_stall),     32'h0);

    in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_valid", 32'(a_out_valid), 32'h1);
    chk("single_data",  a_out_data,       32'hDEADBEEF);
    tick();
    chk("single_drain_valid", 32'(a_out_valid), 32'h0);
    chk("single_drain_occ",   32'(a_occ),       32'h0);

    // Back-pressure fill on the DEPTH=2 stage
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1;
    tick();
    in_data = 32'h2;
    tick();
    in_valid = 1'b0;
    tick();
    chk("bp_in_ready", 32'(a_in_ready), 32'h0);
    chk("bp_occ",      32'(a_occ),      32'h2);
    chk("bp_head",     a_out_data,      32'h1);
    chk("bp_stall",    32'(a_stall),    32'h2);
    out_ready = 1'b1;
    tick();
    chk("bp_second",        a_out_data,      32'h2);
    chk("bp_in_ready_back", 32'(a_in_ready), 32'h1);
    chk("bp_stall_hold",    32'(a_stall),    32'h2);
    tick();
    chk("bp_empty", 32'(a_out_valid), 32'h0);

    // Streaming with pointer wrap on the DEPTH=3 stage
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      tick();
      chk("stream_valid",    32'(b_out_valid), 32'h1);
      chk("stream_data",     b_out_data,       32'(i));
      chk("stream_in_ready", 32'(b_in_ready),  32'h1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end", 32'(b_out_valid), 32'h0);

    // Flush with a colliding push and pop
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    flush = 1'b1; in_data = 32'hAA; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid",    32'(a_out_valid), 32'h0);
    chk("flush_occ",      32'(a_occ),       32'h0);
    chk("flush_in_ready", 32'(a_in_ready),  32'h1);
    chk("flush_b_valid",  32'(b_out_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_no_aa", 32'(b_out_valid), 32'h0);
    end

    // Stall counter saturation and clear
    stat_clr = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55;
    tick();
    stat_clr = 1'b0; in_valid = 1'b0;
    repeat (20) tick();
    chk("sat_b_stall", 32'(b_stall), 32'd15);
    chk("sat_a_stall", 32'(a_stall), 32'd20);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("clr_zero", 32'(b_stall), 32'h0);
    tick();
    chk("clr_count1", 32'(b_stall), 32'h1);

    // Asynchronous reset mid-burst with two entries held
    in_valid = 1'b1; in_data = 32'h66;
    tick();
    in_valid = 1'b0;
    chk("arst_pre_occ", 32'(a_occ), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_a_valid", 32'(a_out_valid), 32'h0);
    chk("arst_a_data",  a_out_data,       32'h0);
    chk("arst_a_ready", 32'(a_in_ready),  32'h1);
    chk("arst_b_valid", 32'(b_out_valid), 32'h0);
    chk("arst_b_data",  b_out_data,       32'h0);
    chk("arst_b_ready", 32'(b_in_ready),  32'h1);
    out_ready = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) tick();

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      stat_clr  = ($urandom_range(0, 31) == 0);
      tick();
    end
    flush = 1'b0; stat_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised elastic pipeline stage: a DEPTH-entry, in-order buffer with valid/ready handshakes on both sides, synchronous flush and a saturating back-pressure counter. It replaces fixed stall/flush stage registers between CPU pipeline stages, such as IF/ID and ID/EX. Stage payloads are passed in as packed structs of `$bits(<stage>_reg_t)` width. The stage decouples upstream from downstream back-pressure without a combinational ready path.

## Interface
- WIDTH, 32, payload width in bits (>=1).
- DEPTH, 2, number of buffer entries (>=1); need not be a power of two.
- CNT_W, 16, width of back-pressure counter.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous kill of all buffered entries.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage can accept; registered, independent of out_ready.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_data  out  WIDTH  head payload; forced '0 when out_valid=0.
- occupancy  out  $clog2(DEPTH+1)  number of valid entries.
- stat_clr  in  1  synchronous clear of stall_cycles.
- stall_cycles  out  CNT_W  saturating count of cycles with out_valid && !out_ready.

## Operation
- Storage: DEPTH×WIDTH array, rd_ptr/wr_ptr in [0, DEPTH-1], count in [0, DEPTH]. Pointers wrap explicitly from DEPTH-1 to 0.
- push = in_valid && in_ready && !flush; pop = out_valid && out_ready && !flush.
- push: mem[wr_ptr] <= in_data; wr_ptr advances. pop: rd_ptr advances.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- in_ready = (count < DEPTH), taken from registered state only. Simultaneous push and pop when full is not possible, because in_ready=0 at full.
- out_valid = (count != 0); out_data = out_valid ? mem[rd_ptr] : '0.
- occupancy = count.
- flush has highest priority:
  - next state is count=0, rd_ptr=wr_ptr=0.
  - Any same-cycle in_valid beat is dropped; upstream treats its own transfer as killed.
  - Any same-cycle out_ready beat is not consumed.
- stall_cycles:
  - increments when out_valid && !out_ready, saturating at 2^CNT_W-1.
  - stat_clr takes priority and sets it to 0.
  - flush does not clear it.
- Reset values: in_ready=1, out_valid=0, out_data=0, occupancy=0, stall_cycles=0, pointers 0. Memory contents are not reset.

## Timing
- Latency: a beat pushed in cycle N is visible on out_* in cycle N+1 (empty-stage case).
- Throughput with DEPTH>=2: 1 beat/cycle sustained while out_ready=1.
- Throughput with DEPTH=1: max 1 beat per 2 cycles, since in_ready is registered.
- in_ready falls the cycle after count reaches DEPTH. It rises the cycle after the pop that frees an entry.
- Output hold: out_valid/out_data stay stable while out_valid && !out_ready, unless flush is asserted.
- Flush timing: out_valid=0 and in_ready=1 in the cycle after flush.
- Reset timing: asynchronous assertion clears all state immediately, including mid-transfer. The first push is possible in the first clk edge after deassertion.

## Structure
- Payload typedefs stay in riscv_pkg (if_id_reg_t, id_ex_reg_t, ex_mem_reg_t, mem_wb_reg_t). Instances pass `$bits()` as WIDTH and cast at the boundary.
- Add to riscv_pkg: `localparam int PIPE_STAGE_DEPTH = 2`, the default for all CPU stages, and `localparam int PIPE_STAT_W = 16`.
- One sub-module: `sat_counter` (parameter W; ports inc, clr; output value), used for stall_cycles.
- Pointer wrap logic stays inline.

## Test plan
- **Reset and single beat:** after reset, expect in_ready=1, out_valid=0, out_data=0. Push 0xDEADBEEF with out_ready=1. Expect out_valid=1 and out_data=0xDEADBEEF the next cycle, then out_valid=0 and occupancy=0.
- **Back-pressure fill (DEPTH=2):** hold out_ready=0 and push 0x1, 0x2. Expect in_ready=0 with occupancy=2. Release out_ready. Expect 0x1 then 0x2 in order, stall_cycles = number of held cycles, and in_ready=1 one cycle after the first pop.
- **Streaming and wrap (DEPTH=3):** with out_ready=1, push 0..9 back-to-back. Expect 10 beats, in order, on consecutive cycles, with no bubbles and in_ready constantly 1.
- **Flush full stage:** fill 2 entries, then assert flush together with in_valid=1 (data 0xAA) and out_ready=1. Next cycle expect out_valid=0, occupancy=0, in_ready=1, and 0xAA never emitted.
- **Counter saturation and clear:** with CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles. Expect stall_cycles=15. Pulse stat_clr together with a stall cycle. Expect 0 next cycle, then counting from 1.
- **Async reset mid-burst:** assert rst_n=0 between clock edges with 2 entries held. Expect out_valid=0, out_data=0, in_ready=1 immediately, and no stale beat emitted after release.
